// File: rtl/servant_ram_arb.sv
// Two-master Wishbone arbiter in front of the single-port servant RAM.
// Round-robin on collisions, return paths gated by grant, watchdog error on stalled grants.
module servant_ram_arb #(
   parameter int aw      = 10,
   parameter int TIMEOUT = 15
) (
   input  logic          i_wb_clk,
   input  logic          i_wb_rst,
   input  logic [aw-3:0] i_wb_m0_adr,
   input  logic [31:0]   i_wb_m0_dat,
   input  logic [3:0]    i_wb_m0_sel,
   input  logic          i_wb_m0_we,
   input  logic          i_wb_m0_cyc,
   output logic [31:0]   o_wb_m0_rdt,
   output logic          o_wb_m0_ack,
   output logic          o_wb_m0_err,
   input  logic [aw-3:0] i_wb_m1_adr,
   input  logic [31:0]   i_wb_m1_dat,
   input  logic [3:0]    i_wb_m1_sel,
   input  logic          i_wb_m1_we,
   input  logic          i_wb_m1_cyc,
   output logic [31:0]   o_wb_m1_rdt,
   output logic          o_wb_m1_ack,
   output logic          o_wb_m1_err,
   output logic [aw-3:0] o_wb_mem_adr,
   output logic [31:0]   o_wb_mem_dat,
   output logic [3:0]    o_wb_mem_sel,
   output logic          o_wb_mem_we,
   output logic          o_wb_mem_cyc,
   input  logic [31:0]   i_wb_mem_rdt,
   input  logic          i_wb_mem_ack
);

   typedef enum logic [1:0] {IDLE, G0, G1} state_e;

   // A zero TIMEOUT still needs a legal one-bit counter; it is simply never compared.
   localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam logic [CW-1:0] CNT_MAX  = '1;

   state_e        state_q, state_d;
   logic          last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic g0, g1, gnt_cyc, expire;

   always_comb begin
      g0      = (state_q == G0);
      g1      = (state_q == G1);
      gnt_cyc = (g0 & i_wb_m0_cyc) | (g1 & i_wb_m1_cyc);
      // Ack on the expiry cycle wins; an aborting master gets no error either.
      expire  = (TIMEOUT != 0) && gnt_cyc && !i_wb_mem_ack && (cnt_q == CNT_LAST);

      o_wb_mem_adr = g0 ? i_wb_m0_adr : g1 ? i_wb_m1_adr : '0;
      o_wb_mem_dat = g0 ? i_wb_m0_dat : g1 ? i_wb_m1_dat : '0;
      o_wb_mem_sel = g0 ? i_wb_m0_sel : g1 ? i_wb_m1_sel : '0;
      o_wb_mem_we  = (g0 & i_wb_m0_we) | (g1 & i_wb_m1_we);
      o_wb_mem_cyc = gnt_cyc;

      o_wb_m0_ack = g0 & i_wb_mem_ack;
      o_wb_m0_err = g0 & expire;
      o_wb_m0_rdt = g0 ? i_wb_mem_rdt : '0;
      o_wb_m1_ack = g1 & i_wb_mem_ack;
      o_wb_m1_err = g1 & expire;
      o_wb_m1_rdt = g1 ? i_wb_mem_rdt : '0;
   end

   always_comb begin
      // NOTE: every next-state variable gets a default first so no path infers a latch.
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (i_wb_m0_cyc && i_wb_m1_cyc) begin
               state_d = last_q ? G0 : G1;
               last_d  = !last_q;
            end else if (i_wb_m0_cyc) begin
               state_d = G0;
            end else if (i_wb_m1_cyc) begin
               state_d = G1;
            end
         end
         G0: if (i_wb_mem_ack || !i_wb_m0_cyc || expire) state_d = IDLE;
         G1: if (i_wb_mem_ack || !i_wb_m1_cyc || expire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
      if (i_wb_rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_servant_ram_arb.sv
// Scoreboard bench for servant_ram_arb: stimulus queues expected responses,
// a monitor process pops and compares whenever a master sees ack or err.
module tb_servant_ram_arb;

   localparam int AW = 10;

   typedef struct {
      int          cyc;
      bit          err;
      bit          chk;
      logic [31:0] rdt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hang = 1'b0;
   int   cyc_cnt = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb0[$];
   exp_t sb1[$];

   logic [AW-3:0] m_adr [2];
   logic [31:0]   m_dat [2];
   logic [3:0]    m_sel [2];
   logic          m_we  [2];
   logic          m_cyc [2];

   logic [31:0]   m0_rdt, m1_rdt, mem_dat, ram_rdt;
   logic          m0_ack, m0_err, m1_ack, m1_err, mem_we, mem_cyc, ram_ack;
   logic [AW-3:0] mem_adr;
   logic [3:0]    mem_sel;
   logic [31:0]   ram [256];

   // Second instance with the watchdog disabled; its RAM never acks.
   logic          n_cyc = 1'b0;
   logic [31:0]   n_m0_rdt, n_m1_rdt, n_mem_dat;
   logic          n_m0_ack, n_m0_err, n_m1_ack, n_m1_err, n_mem_we, n_mem_cyc;
   logic [AW-3:0] n_mem_adr;
   logic [3:0]    n_mem_sel;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   servant_ram_arb #(.aw(AW), .TIMEOUT(4)) u_dut (
      .i_wb_clk(clk), .i_wb_rst(rst),
      .i_wb_m0_adr(m_adr[0]), .i_wb_m0_dat(m_dat[0]), .i_wb_m0_sel(m_sel[0]),
      .i_wb_m0_we(m_we[0]), .i_wb_m0_cyc(m_cyc[0]),
      .o_wb_m0_rdt(m0_rdt), .o_wb_m0_ack(m0_ack), .o_wb_m0_err(m0_err),
      .i_wb_m1_adr(m_adr[1]), .i_wb_m1_dat(m_dat[1]), .i_wb_m1_sel(m_sel[1]),
      .i_wb_m1_we(m_we[1]), .i_wb_m1_cyc(m_cyc[1]),
      .o_wb_m1_rdt(m1_rdt), .o_wb_m1_ack(m1_ack), .o_wb_m1_err(m1_err),
      .o_wb_mem_adr(mem_adr), .o_wb_mem_dat(mem_dat), .o_wb_mem_sel(mem_sel),
      .o_wb_mem_we(mem_we), .o_wb_mem_cyc(mem_cyc),
      .i_wb_mem_rdt(ram_rdt), .i_wb_mem_ack(ram_ack)
   );

   servant_ram_arb #(.aw(AW), .TIMEOUT(0)) u_nowd (
      .i_wb_clk(clk), .i_wb_rst(rst),
      .i_wb_m0_adr(8'h12), .i_wb_m0_dat(32'h0), .i_wb_m0_sel(4'hF),
      .i_wb_m0_we(1'b0), .i_wb_m0_cyc(n_cyc),
      .o_wb_m0_rdt(n_m0_rdt), .o_wb_m0_ack(n_m0_ack), .o_wb_m0_err(n_m0_err),
      .i_wb_m1_adr(8'h0), .i_wb_m1_dat(32'h0), .i_wb_m1_sel(4'h0),
      .i_wb_m1_we(1'b0), .i_wb_m1_cyc(1'b0),
      .o_wb_m1_rdt(n_m1_rdt), .o_wb_m1_ack(n_m1_ack), .o_wb_m1_err(n_m1_err),
      .o_wb_mem_adr(n_mem_adr), .o_wb_mem_dat(n_mem_dat), .o_wb_mem_sel(n_mem_sel),
      .o_wb_mem_we(n_mem_we), .o_wb_mem_cyc(n_mem_cyc),
      .i_wb_mem_rdt(32'h0), .i_wb_mem_ack(1'b0)
   );

   // Servant-style RAM: acks the cycle after cyc, byte-lane writes, registered read data.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_ack <= 1'b0;
         ram_rdt <= 32'h0;
      end else begin
         ram_ack <= mem_cyc & !ram_ack & !hang;
         if (mem_cyc && !ram_ack) begin
            if (mem_we)
               for (int b = 0; b < 4; b++)
                  if (mem_sel[b]) ram[mem_adr][8*b +: 8] <= mem_dat[8*b +: 8];
            ram_rdt <= ram[mem_adr];
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   task automatic handle(input int m, input logic ack, input logic err, input logic [31:0] rdt,
                         input logic [33:0] other);
      exp_t e;
      int   n = (m == 0) ? sb0.size() : sb1.size();
      if (n == 0) begin
         check($sformatf("m%0d unexpected response", m), 64'(n), 64'd1);
         return;
      end
      e = (m == 0) ? sb0.pop_front() : sb1.pop_front();
      check($sformatf("m%0d response cycle", m), 64'(cyc_cnt), 64'(e.cyc));
      check($sformatf("m%0d err flag", m), 64'(err), 64'(e.err));
      check($sformatf("m%0d ack flag", m), 64'(ack), 64'(!e.err));
      if (e.chk) check($sformatf("m%0d read data", m), 64'(rdt), 64'(e.rdt));
      check($sformatf("m%0d other master quiet", m), 64'(other), 64'd0);
   endtask

   task automatic start(input int m, input bit we, input logic [7:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int dly, input bit err, input bit chk,
                        input logic [31:0] rdt);
      exp_t e;
      @(posedge clk);
      #1;
      m_adr[m] = adr;
      m_dat[m] = dat;
      m_sel[m] = sel;
      m_we[m]  = we;
      m_cyc[m] = 1'b1;
      e = '{cyc: cyc_cnt + dly, err: err, chk: chk, rdt: rdt};
      if (m == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   task automatic finish(input int m);
      bit done = 1'b0;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         done = (m == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err);
      end
      check($sformatf("m%0d response within budget", m), 64'(done), 64'd1);
      @(posedge clk);
      #1;
      check($sformatf("m%0d port idle after response", m), 64'(mem_cyc), 64'd0);
      m_cyc[m] = 1'b0;
      m_we[m]  = 1'b0;
   endtask

   task automatic xact(input int m, input bit we, input logic [7:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int dly, input bit chk, input logic [31:0] rdt);
      start(m, we, adr, dat, sel, dly, 1'b0, chk, rdt);
      finish(m);
   endtask

   task automatic check_all_zero(input string name);
      check(name, {mem_cyc, mem_we, mem_sel, mem_adr, m0_ack, m0_err, m1_ack, m1_err}, 64'd0);
      check({name, " data"}, {mem_dat, m0_rdt | m1_rdt}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL time limit: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int m = 0; m < 2; m++) begin
         m_adr[m] = '0; m_dat[m] = '0; m_sel[m] = '0; m_we[m] = 1'b0; m_cyc[m] = 1'b0;
      end
      fork
         forever begin
            @(negedge clk);
            if (m0_ack || m0_err) handle(0, m0_ack, m0_err, m0_rdt, {m1_ack, m1_err, m1_rdt});
            if (m1_ack || m1_err) handle(1, m1_ack, m1_err, m1_rdt, {m0_ack, m0_err, m0_rdt});
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset outputs");
      rst = 1'b0;

      // Single master write then read back.
      xact(0, 1'b1, 8'h05, 32'hDEADBEEF, 4'hF, 2, 1'b0, 32'h0);
      xact(0, 1'b0, 8'h05, 32'h0, 4'hF, 2, 1'b1, 32'hDEADBEEF);

      // Reset mid-grant: outputs drop at once, the transfer is never acked.
      @(posedge clk);
      #1;
      m_adr[0] = 8'h07; m_we[0] = 1'b1; m_dat[0] = 32'hA5A5A5A5; m_sel[0] = 4'hF; m_cyc[0] = 1'b1;
      @(posedge clk);
      #1;
      check("grant before reset", {mem_cyc, mem_adr}, {1'b1, 8'h07});
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async reset outputs");
      @(posedge clk);
      #1;
      m_cyc[0] = 1'b0; m_we[0] = 1'b0;
      rst = 1'b0;

      // Collisions: m0 wins first, then grants alternate.
      for (int i = 0; i < 8; i++) begin
         fork
            xact(0, 1'b1, 8'(16 + i), 32'(i), 4'hF, (i % 2 == 0) ? 2 : 5, 1'b0, 32'h0);
            xact(1, 1'b1, 8'(32 + i), 32'h100 + 32'(i), 4'hF, (i % 2 == 0) ? 5 : 2, 1'b0, 32'h0);
         join
      end
      xact(0, 1'b0, 8'd35, 32'h0, 4'hF, 2, 1'b1, 32'h103);

      // Byte lanes, then a sel=0 write that must be acked but change nothing.
      xact(1, 1'b1, 8'h40, 32'hFFFFFFFF, 4'hF, 2, 1'b0, 32'h0);
      xact(1, 1'b1, 8'h40, 32'h11223344, 4'b0101, 2, 1'b0, 32'h0);
      xact(1, 1'b0, 8'h40, 32'h0, 4'hF, 2, 1'b1, 32'hFF22FF44);
      xact(0, 1'b1, 8'h40, 32'h0, 4'h0, 2, 1'b0, 32'h0);
      xact(0, 1'b0, 8'h40, 32'h0, 4'hF, 2, 1'b1, 32'hFF22FF44);

      // Abort: m1 drops cyc one cycle into its grant, pending m0 is served next.
      hang = 1'b1;
      @(posedge clk);
      #1;
      m_adr[1] = 8'h40; m_we[1] = 1'b0; m_sel[1] = 4'hF; m_cyc[1] = 1'b1;
      start(0, 1'b0, 8'h05, 32'h0, 4'hF, 4, 1'b0, 1'b1, 32'hDEADBEEF);
      check("m1 granted", {mem_cyc, mem_adr}, {1'b1, 8'h40});
      @(posedge clk);
      #1;
      m_cyc[1] = 1'b0;
      hang = 1'b0;
      #1;
      check("abort drops mem cyc", 64'(mem_cyc), 64'd0);
      finish(0);

      // Watchdog with TIMEOUT=4: err in the 4th grant cycle, then idle.
      hang = 1'b1;
      start(0, 1'b0, 8'h05, 32'h0, 4'hF, 4, 1'b1, 1'b0, 32'h0);
      finish(0);
      hang = 1'b0;

      // TIMEOUT=0: the grant holds without limit.
      @(posedge clk);
      #1;
      n_cyc = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("no watchdog hold 20", {n_mem_cyc, n_m0_err, n_m0_ack, n_mem_adr}, {3'b100, 8'h12});
      repeat (40) @(posedge clk);
      #1;
      check("no watchdog hold 60", {n_mem_cyc, n_m0_err, n_m0_ack}, 64'b100);
      n_cyc = 1'b0;
      #1;
      check("no watchdog release", 64'(n_mem_cyc), 64'd0);

      repeat (5) @(posedge clk);
      check("m0 scoreboard drained", 64'(sb0.size()), 64'd0);
      check("m1 scoreboard drained", 64'(sb1.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
